// File: rtl/temp_log_readport_bridge.sv
// Circular temperature log with a toggle-handshake read port for a 20-bit GPIO pair.
// Read latency is 3 clocks from toggle detection to the ack. There is no backpressure: samples are always accepted.
module temp_log_readport_bridge #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_data,
    input  logic          log_clear,
    input  logic [19:0]   cmd_word,
    output logic [19:0]   rsp_word,
    output logic [AW:0]   fill_count,
    output logic          busy
);
    localparam int DEPTH = 1 << AW;
    localparam int FW    = AW + 1;

    typedef enum logic [1:0] {IDLE, CALC, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   ram [DEPTH];
    logic [DW-1:0]   rd_data;
    logic [AW-1:0]   wr_ptr, wr_addr;
    logic            req_seen, mode_q, err_q;
    logic [9:0]      idx_q;
    logic [AW-1:0]   wr_snap;
    logic [FW-1:0]   fill_snap;
    logic            new_req, rd_en, rsp_load;
    logic [AW-1:0]   phys;
    logic            calc_err;
    logic [10:0]     idx_x, fill_x;
    logic            unused_cmd_bits;

    assign unused_cmd_bits = ^cmd_word[17:10];
    assign new_req = (state == IDLE) && (cmd_word[19] != req_seen);

    // A clear in the same cycle as a sample puts that sample at slot 0.
    assign wr_addr = log_clear ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            fill_count <= '0;
        end else if (log_clear) begin
            wr_ptr     <= sample_valid ? AW'(1) : '0;
            fill_count <= sample_valid ? FW'(1) : '0;
        end else if (sample_valid) begin
            wr_ptr     <= wr_ptr + AW'(1);
            fill_count <= (fill_count == FW'(DEPTH)) ? fill_count : fill_count + FW'(1);
        end
    end

    // Non-blocking read and write give read-before-write on an address collision.
    always_ff @(posedge clk) begin
        if (sample_valid)
            ram[wr_addr] <= sample_data;
        if (rd_en)
            rd_data <= ram[phys];
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (new_req) state_nxt = CALC;
            CALC: state_nxt = WAIT;
            WAIT: state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        rd_en    = (state == CALC);
        rsp_load = (state == RESP);
    end

    always_comb begin
        idx_x  = {1'b0, idx_q};
        fill_x = 11'(fill_snap);
        if (mode_q) begin
            phys     = wr_snap - AW'(1) - idx_q[AW-1:0];
            calc_err = (idx_x >= fill_x);
        end else begin
            phys     = idx_q[AW-1:0];
            calc_err = (idx_x >= 11'(DEPTH)) || (idx_x >= fill_x);
        end
    end

    // Snapshots are taken before any same-edge write lands, excluding that sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_seen  <= 1'b0;
            rsp_word  <= '0;
            mode_q    <= 1'b0;
            idx_q     <= '0;
            wr_snap   <= '0;
            fill_snap <= '0;
            err_q     <= 1'b0;
        end else begin
            if (new_req) begin
                req_seen  <= cmd_word[19];
                mode_q    <= cmd_word[18];
                idx_q     <= cmd_word[9:0];
                wr_snap   <= wr_ptr;
                fill_snap <= fill_count;
            end
            if (rd_en)
                err_q <= calc_err;
            if (rsp_load)
                rsp_word <= {req_seen, err_q, 2'b00, err_q ? 16'h0000 : 16'(rd_data)};
        end
    end
endmodule

// File: tb/tb_temp_log_readport_bridge.sv
// Directed bench for temp_log_readport_bridge with hand-computed expected responses.
module tb_temp_log_readport_bridge;
    logic        clk;
    logic        reset;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        log_clear;
    logic [19:0] cmd_word;
    logic [19:0] rsp_word;
    logic [8:0]  fill_count;
    logic        busy;

    int          tests = 0;
    int          fails = 0;
    logic        tog = 1'b0;
    logic [19:0] last_rsp = 20'h0;

    temp_log_readport_bridge #(.AW(8), .DW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .log_clear    (log_clear),
        .cmd_word     (cmd_word),
        .rsp_word     (rsp_word),
        .fill_count   (fill_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_sample(input logic [15:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    // Flips the toggle, optionally writes 0xAAAA on the detection edge and 0xBBBB
    // on the CALC edge, scrambles the non-toggle fields after detection, and checks
    // busy, the unchanged response at N+2 and the new response at N+3.
    task automatic do_read(input string tag, input logic mode, input logic [9:0] idx,
                           input logic sv_det, input logic sv_calc, input logic [19:0] exp);
        tog          = ~tog;
        cmd_word     = {tog, mode, 8'h00, idx};
        sample_valid = sv_det;
        sample_data  = 16'hAAAA;
        tick();
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        cmd_word     = {tog, ~mode, 8'hFF, ~idx};
        sample_valid = sv_calc;
        sample_data  = 16'hBBBB;
        tick();
        sample_valid = 1'b0;
        tick();
        chk({tag, "_lat"}, {12'b0, rsp_word}, {12'b0, last_rsp});
        tick();
        chk(tag, {12'b0, rsp_word}, {12'b0, exp});
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
        last_rsp = exp;
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = 16'h0;
        log_clear    = 1'b0;
        cmd_word     = 20'h0;
        tick();
        tick();
        chk("rst_rsp",  {12'b0, rsp_word},   32'h0);
        chk("rst_fill", {23'b0, fill_count}, 32'h0);
        chk("rst_busy", {31'b0, busy},       32'h0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++)
            write_sample(16'h0100 + 16'(i));
        chk("fill5", {23'b0, fill_count}, 32'd5);
        do_read("m1_age0",  1'b1, 10'd0, 1'b0, 1'b0, 20'h80104);
        do_read("m0_idx2",  1'b0, 10'd2, 1'b0, 1'b0, 20'h00102);
        do_read("m0_idx5",  1'b0, 10'd5, 1'b0, 1'b0, 20'hC0000);

        log_clear = 1'b1;
        tick();
        log_clear = 1'b0;
        chk("clr_fill", {23'b0, fill_count}, 32'd0);
        for (int i = 0; i < 300; i++)
            write_sample(16'(i));
        chk("fill_sat", {23'b0, fill_count}, 32'd256);
        do_read("m1_age255", 1'b1, 10'd255, 1'b0, 1'b0, 20'h0002C);
        do_read("m1_age256", 1'b1, 10'd256, 1'b0, 1'b0, 20'hC0000);
        do_read("m0_idx300", 1'b0, 10'd300, 1'b0, 1'b0, 20'h40000);

        do_read("wdr_snap",  1'b1, 10'd0,  1'b1, 1'b1, 20'h8012B);
        do_read("wdr_new",   1'b1, 10'd0,  1'b0, 1'b0, 20'h0BBBB);
        do_read("wdr_rbw",   1'b0, 10'd46, 1'b0, 1'b1, 20'h8002E);

        log_clear    = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 16'hBEEF;
        tick();
        log_clear    = 1'b0;
        sample_valid = 1'b0;
        chk("clr_wr_fill", {23'b0, fill_count}, 32'd1);
        do_read("clr_idx0", 1'b0, 10'd0, 1'b0, 1'b0, 20'h0BEEF);
        do_read("clr_idx1", 1'b0, 10'd1, 1'b0, 1'b0, 20'hC0000);

        tog      = ~tog;
        cmd_word = {tog, 1'b0, 8'h00, 10'd0};
        tick();
        tick();
        reset    = 1'b1;
        cmd_word = 20'h0;
        tick();
        reset    = 1'b0;
        chk("abort_rsp",  {12'b0, rsp_word},   32'h0);
        chk("abort_busy", {31'b0, busy},       32'h0);
        chk("abort_fill", {23'b0, fill_count}, 32'h0);
        tick();
        tick();
        chk("abort_noack", {12'b0, rsp_word}, 32'h0);
        tog      = 1'b0;
        last_rsp = 20'h0;
        write_sample(16'h1234);
        do_read("post_rst", 1'b0, 10'd0, 1'b0, 1'b0, 20'h81234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
